// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port DataMemory between the CPU memory
// stage (port c) and a debug/loader port (port d). Each access is a fixed
// capture -> one ACCESS cycle -> registered read-data response.
// Build option: define DMEM_ARB_CPU_PRIORITY_EN to give the CPU fixed
// priority on simultaneous requests (default is round-robin).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  c_stall_cnt
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_C, PORT_D} port_t;

  state_t state_q, state_d;
  port_t  owner_q, owner_d;
  port_t  last_q, last_d;

  logic              c_gnt_q, c_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              c_rvalid_q, c_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  c_stall_q, c_stall_d;
  logic              pick_c, pick_d;

  // State register and all registered outputs; reset wins over any activity
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= PORT_C;
      last_q      <= PORT_D;
      c_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      c_rvalid_q  <= 1'b0;
      d_rvalid_q  <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_stall_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      c_gnt_q     <= c_gnt_d;
      d_gnt_q     <= d_gnt_d;
      c_rvalid_q  <= c_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_stall_q   <= c_stall_d;
    end
  end

  // Next-state: arbitration in IDLE, response and release in ACCESS, stall count
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    c_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    c_rvalid_d  = 1'b0;
    d_rvalid_d  = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c_stall_d   = c_stall_q;
    pick_c      = 1'b0;
    pick_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (c_req && d_req) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
          pick_c = 1'b1;
`else
          if (last_q == PORT_D) pick_c = 1'b1;
          else                  pick_d = 1'b1;
`endif
        end else if (c_req) begin
          pick_c = 1'b1;
        end else if (d_req) begin
          pick_d = 1'b1;
        end

        if (pick_c) begin
          state_d     = ACCESS;
          owner_d     = PORT_C;
          c_gnt_d     = 1'b1;
          mem_we_d    = c_we;
          mem_addr_d  = c_addr;
          mem_wdata_d = c_wdata;
        end else if (pick_d) begin
          state_d     = ACCESS;
          owner_d     = PORT_D;
          d_gnt_d     = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        last_d  = owner_q;
        if (!mem_we_q) begin
          if (owner_q == PORT_C) begin
            c_rdata_d  = mem_rdata;
            c_rvalid_d = 1'b1;
          end else begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end
        end
      end
    endcase

    if (c_req && !(state_q == ACCESS && owner_q == PORT_C) && (c_stall_q != '1))
      c_stall_d = c_stall_q + CNT_W'(1);
  end

  // mem_we is gated by rst_n so a reset asserted during ACCESS also blocks
  // the write that DataMemory would otherwise commit on the reset edge.
  assign mem_we      = mem_we_q & rst_n;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign c_gnt       = c_gnt_q;
  assign d_gnt       = d_gnt_q;
  assign c_rvalid    = c_rvalid_q;
  assign d_rvalid    = d_rvalid_q;
  assign c_rdata     = c_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign c_stall_cnt = c_stall_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// DataMemory (posedge write, combinational read). Honours
// DMEM_ARB_CPU_PRIORITY_EN for the arbitration expectations.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        c_req, c_we, d_req, d_we;
  logic [15:0] c_addr, d_addr;
  logic [31:0] c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  c_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:65535];
  logic        mem_ready = 1'b0;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .c_stall_cnt(c_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DataMemory; first edge preloads zeros and addr 7 = 0x77
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 32'h0;
      mem[7]    <= 32'h0000_0077;
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " c_gnt"},     {31'b0, c_gnt},    32'h0);
    check({tag, " d_gnt"},     {31'b0, d_gnt},    32'h0);
    check({tag, " c_rvalid"},  {31'b0, c_rvalid}, 32'h0);
    check({tag, " d_rvalid"},  {31'b0, d_rvalid}, 32'h0);
    check({tag, " c_rdata"},   c_rdata,           32'h0);
    check({tag, " d_rdata"},   d_rdata,           32'h0);
    check({tag, " mem_we"},    {31'b0, mem_we},   32'h0);
    check({tag, " mem_addr"},  {16'b0, mem_addr}, 32'h0);
    check({tag, " mem_wdata"}, mem_wdata,         32'h0);
    check({tag, " stall"},     {28'b0, c_stall_cnt}, 32'h0);
  endtask

  initial begin
    logic cwin;
    int   exp_stall;

    rst_n = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle_zero("reset");

    // CPU write 0xDEADBEEF to addr 5
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'd5; c_wdata = 32'hDEADBEEF;
    tick();
    check("wr c_gnt",    {31'b0, c_gnt},    32'h1);
    check("wr d_gnt",    {31'b0, d_gnt},    32'h0);
    check("wr mem_we",   {31'b0, mem_we},   32'h1);
    check("wr mem_addr", {16'b0, mem_addr}, 32'h5);
    check("wr mem_wdata", mem_wdata,        32'hDEADBEEF);
    check("wr c_rvalid", {31'b0, c_rvalid}, 32'h0);
    check("wr stall",    {28'b0, c_stall_cnt}, 32'h1);
    c_req = 1'b0;
    tick();
    check("wr done gnt",    {31'b0, c_gnt},    32'h0);
    check("wr done mem_we", {31'b0, mem_we},   32'h0);
    check("wr done rvalid", {31'b0, c_rvalid}, 32'h0);
    check("wr mem5",        mem[5],            32'hDEADBEEF);

    // CPU read-back of addr 5
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd5; c_wdata = 32'h0;
    tick();
    check("rd c_gnt",  {31'b0, c_gnt},  32'h1);
    check("rd mem_we", {31'b0, mem_we}, 32'h0);
    check("rd rvalid early", {31'b0, c_rvalid}, 32'h0);
    c_req = 1'b0;
    tick();
    check("rd c_rvalid", {31'b0, c_rvalid}, 32'h1);
    check("rd c_rdata",  c_rdata,           32'hDEADBEEF);
    check("rd c_gnt off", {31'b0, c_gnt},   32'h0);
    tick();
    check("rd rvalid pulse", {31'b0, c_rvalid}, 32'h0);
    check("rd rdata hold",   c_rdata,           32'hDEADBEEF);
    check("rd stall",        {28'b0, c_stall_cnt}, 32'h2);

    // Debug read of addr 5 while CPU idle
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd5;
    tick();
    check("dbg d_gnt", {31'b0, d_gnt}, 32'h1);
    check("dbg c_gnt", {31'b0, c_gnt}, 32'h0);
    d_req = 1'b0;
    tick();
    check("dbg d_rvalid", {31'b0, d_rvalid}, 32'h1);
    check("dbg d_rdata",  d_rdata,           32'hDEADBEEF);
    check("dbg c_rvalid", {31'b0, c_rvalid}, 32'h0);
    check("dbg c_rdata",  c_rdata,           32'hDEADBEEF);
    check("dbg stall",    {28'b0, c_stall_cnt}, 32'h2);
    tick();
    check("dbg rvalid pulse", {31'b0, d_rvalid}, 32'h0);

    // Simultaneous requests straight out of reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("sim reset stall", {28'b0, c_stall_cnt}, 32'h0);
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd5;
    exp_stall = 0;
    for (int r = 0; r < 4; r++) begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
      cwin = 1'b1;
`else
      cwin = (r % 2 == 0);
`endif
      tick();
      exp_stall++;  // arbitration cycle in IDLE
      check($sformatf("sim r%0d c_gnt", r), {31'b0, c_gnt}, {31'b0, cwin});
      check($sformatf("sim r%0d d_gnt", r), {31'b0, d_gnt}, {31'b0, ~cwin});
      check($sformatf("sim r%0d stall a", r), {28'b0, c_stall_cnt}, exp_stall);
      tick();
      if (!cwin) exp_stall++;  // debug ACCESS cycle also stalls the CPU
      check($sformatf("sim r%0d c_rvalid", r), {31'b0, c_rvalid}, {31'b0, cwin});
      check($sformatf("sim r%0d d_rvalid", r), {31'b0, d_rvalid}, {31'b0, ~cwin});
      check($sformatf("sim r%0d stall b", r), {28'b0, c_stall_cnt}, exp_stall);
    end
    c_req = 1'b0; d_req = 1'b0;

    // Reset during a CPU write ACCESS to addr 7
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'd7; c_wdata = 32'h1;
    tick();
    check("mid c_gnt",  {31'b0, c_gnt},  32'h1);
    check("mid mem_we", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    c_req = 1'b0;
    #1;
    check("mid mem_we gated", {31'b0, mem_we}, 32'h0);
    tick();
    check_idle_zero("midrst");
    check("mid mem7", mem[7], 32'h0000_0077);
    rst_n = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd7; c_wdata = 32'h0;
    tick();
    c_req = 1'b0;
    tick();
    check("mid rd rvalid", {31'b0, c_rvalid}, 32'h1);
    check("mid rd rdata",  c_rdata,           32'h0000_0077);

    // Stall counter saturation (CNT_W=4) under continuous contention
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'd5;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'd5;
    for (int k = 0; k < 8; k++) tick();
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    check("sat mid", {28'b0, c_stall_cnt}, 32'h4);
`else
    check("sat mid", {28'b0, c_stall_cnt}, 32'h6);
`endif
    for (int k = 0; k < 32; k++) tick();
    check("sat top", {28'b0, c_stall_cnt}, 32'hF);
    for (int k = 0; k < 7; k++) tick();
    check("sat hold", {28'b0, c_stall_cnt}, 32'hF);
    c_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
